coin_acceptor: RTL and testbench

//  Front-end stage feeding the vending-machine FSM. Conditions the raw coin-slot sensor, measures each coin's

---
 rtl/coin_acceptor.sv | 169 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the sensor, times each coin pulse and drives
// a one-cycle coin code (or reject) onto the shared coin bus; a stuck-high sensor raises jam.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned T25_MIN         = 4,
    parameter int unsigned T25_MAX         = 7,
    parameter int unsigned T50_MIN         = 10,
    parameter int unsigned T50_MAX         = 15,
    parameter int unsigned T100_MIN        = 20,
    parameter int unsigned T100_MAX        = 31,
    parameter int unsigned GAP_CYCLES      = 8,
    parameter int unsigned JAM_CYCLES      = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor_in,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       coin_strobe,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    localparam logic [1:0] Coin25  = 2'b00;
    localparam logic [1:0] Coin50  = 2'b01;
    localparam logic [1:0] Coin100 = 2'b10;
    localparam logic [1:0] NoCoin  = 2'b11;

    localparam logic [7:0] DebLast  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] JamWidth = 8'(JAM_CYCLES);
    localparam logic [7:0] W25Min   = 8'(T25_MIN);
    localparam logic [7:0] W25Max   = 8'(T25_MAX);
    localparam logic [7:0] W50Min   = 8'(T50_MIN);
    localparam logic [7:0] W50Max   = 8'(T50_MAX);
    localparam logic [7:0] W100Min  = 8'(T100_MIN);
    localparam logic [7:0] W100Max  = 8'(T100_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StMeasure,
        StClassify,
        StGap,
        StJam
    } state_e;

    logic       sync1_q, sync2_q;
    logic       db_q, db_d;
    logic [7:0] db_cnt_q, db_cnt_d;
    state_e     state_q, state_d;
    logic [7:0] width_q, width_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       taint_q, taint_d;
    logic [7:0] width_inc;
    logic       in_25, in_50, in_100;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= StIdle;
            width_q   <= '0;
            gap_cnt_q <= '0;
            taint_q   <= 1'b0;
        end else begin
            sync1_q   <= sensor_in;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            width_q   <= width_d;
            gap_cnt_q <= gap_cnt_d;
            taint_q   <= taint_d;
        end
    end

    // Debounced level follows the synced sensor only after it has differed for DEBOUNCE_CYCLES.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DebLast) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    assign width_inc = (width_q == 8'hff) ? width_q : width_q + 8'd1;
    assign in_25     = (width_q >= W25Min) && (width_q <= W25Max);
    assign in_50     = (width_q >= W50Min) && (width_q <= W50Max);
    assign in_100    = (width_q >= W100Min) && (width_q <= W100Max);

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        gap_cnt_d   = gap_cnt_q;
        taint_d     = taint_q;
        coin        = NoCoin;
        coin_strobe = 1'b0;
        reject      = 1'b0;
        jam         = 1'b0;
        busy        = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (db_q) begin
                    state_d = StMeasure;
                    width_d = 8'd1;
                    taint_d = ~enable;
                end
            end
            StMeasure: begin
                if (db_q) begin
                    width_d = width_inc;
                    if (width_inc >= JamWidth) begin
                        state_d = StJam;
                    end
                end else begin
                    state_d = StClassify;
                end
            end
            StClassify: begin
                if (taint_q) begin
                    reject = 1'b1;
                end else if (in_25) begin
                    coin        = Coin25;
                    coin_strobe = 1'b1;
                end else if (in_50) begin
                    coin        = Coin50;
                    coin_strobe = 1'b1;
                end else if (in_100) begin
                    coin        = Coin100;
                    coin_strobe = 1'b1;
                end else begin
                    reject = 1'b1;
                end
                state_d   = StGap;
                gap_cnt_d = '0;
            end
            StGap: begin
                // A coin arriving during lockout is still timed, but always refused.
                if (db_q) begin
                    state_d = StMeasure;
                    width_d = 8'd1;
                    taint_d = 1'b1;
                end else if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            StJam: begin
                jam = 1'b1;
                if (!db_q) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: builds raw sensor/enable waveforms, predicts every output cycle from
// pulse-level rules (widths, lockout windows, fixed latencies) and compares cycle by cycle.
module tb_coin_acceptor;

    localparam int MAXC     = 3000;
    localparam int DEB      = 3;
    localparam int JAMW     = 64;
    localparam int GAPW     = 8;
    localparam int LAT_RISE = 2 + DEB + 1;
    localparam int LAT_FALL = 2 + DEB + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       sensor_in;
    logic       enable;
    logic [1:0] coin;
    logic       coin_strobe;
    logic       reject;
    logic       jam;
    logic       busy;

    coin_acceptor dut (
        .clock       (clock),
        .reset       (reset),
        .sensor_in   (sensor_in),
        .enable      (enable),
        .coin        (coin),
        .coin_strobe (coin_strobe),
        .reject      (reject),
        .jam         (jam),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    bit raw_a[MAXC];
    bit en_a[MAXC];
    int e_coin[MAXC];
    bit e_strobe[MAXC];
    bit e_reject[MAXC];
    bit e_jam[MAXC];
    bit e_busy[MAXC];
    int len;
    bit en_cur;
    int blist[16] = '{3, 4, 7, 8, 9, 10, 15, 16, 19, 20, 31, 32, 63, 64, 5, 12};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic add_seg(input bit level, input int n);
        for (int i = 0; i < n; i++) begin
            if (len >= MAXC) begin
                $display("FAIL stimulus_overflow: got %0d, expected < %0d", len, MAXC);
                $fatal(1, "stimulus buffer overflow");
            end
            raw_a[len] = level;
            en_a[len]  = en_cur;
            len++;
        end
    endtask

    task automatic pulse(input int n, input int low);
        add_seg(1'b1, n);
        add_seg(1'b0, low);
    endtask

    function automatic int classify(input int n);
        if (n >= 4 && n <= 7) return 0;
        if (n >= 10 && n <= 15) return 1;
        if (n >= 20 && n <= 31) return 2;
        return 3;
    endfunction

    function automatic void mark(input int lo, input int hi, input int what);
        for (int t = lo; t <= hi; t++) begin
            if (t >= 0 && t < len) begin
                if (what == 0) e_busy[t] = 1'b1;
                else e_jam[t] = 1'b1;
            end
        end
    endfunction

    // Pulse-level prediction: every raw high run of DEB+ cycles is a coin of that width.
    task automatic build_model();
        int c, tr, tf, n, code, gap_lo, gap_hi, seen, t;
        bit taint;
        for (int i = 0; i < len; i++) begin
            e_coin[i]   = 3;
            e_strobe[i] = 1'b0;
            e_reject[i] = 1'b0;
            e_jam[i]    = 1'b0;
            e_busy[i]   = 1'b0;
        end
        gap_lo = -100;
        gap_hi = -100;
        c = 0;
        while (c < len) begin
            if (raw_a[c] && (c == 0 || !raw_a[c-1])) begin
                tr = c;
                tf = c;
                while (tf < len && raw_a[tf]) tf++;
                n = tf - tr;
                if (n >= DEB) begin
                    seen  = tr + LAT_RISE - 1;
                    taint = !en_a[seen] || (seen >= gap_lo && seen <= gap_hi);
                    if (n >= JAMW) begin
                        mark(seen + JAMW, tf + LAT_FALL - 1, 1);
                        gap_lo = tf + LAT_FALL;
                        gap_hi = gap_lo + GAPW - 1;
                        mark(tr + LAT_RISE, gap_hi, 0);
                    end else begin
                        t = tf + LAT_FALL;
                        code = classify(n);
                        if (taint || code == 3) begin
                            e_reject[t] = 1'b1;
                        end else begin
                            e_coin[t]   = code;
                            e_strobe[t] = 1'b1;
                        end
                        gap_lo = t + 1;
                        gap_hi = gap_lo + GAPW - 1;
                        mark(tr + LAT_RISE, gap_hi, 0);
                    end
                end
                c = tf;
            end else begin
                c++;
            end
        end
    endtask

    task automatic play();
        reset     = 1'b1;
        sensor_in = 1'b0;
        enable    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_coin", int'(coin), 3);
        check("rst_strobe", int'(coin_strobe), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_jam", int'(jam), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (c != 0) begin
                @(posedge clock);
                #1;
            end
            check($sformatf("coin@%0d", c), int'(coin), e_coin[c]);
            check($sformatf("strobe@%0d", c), int'(coin_strobe), int'(e_strobe[c]));
            check($sformatf("reject@%0d", c), int'(reject), int'(e_reject[c]));
            check($sformatf("jam@%0d", c), int'(jam), int'(e_jam[c]));
            check($sformatf("busy@%0d", c), int'(busy), int'(e_busy[c]));
            sensor_in = raw_a[c];
            enable    = en_a[c];
        end
    endtask

    task automatic gen_directed();
        len    = 0;
        en_cur = 1'b1;
        add_seg(1'b0, 10);
        pulse(5, 40);
        pulse(10, 40);
        pulse(15, 40);
        pulse(31, 40);
        pulse(3, 40);
        pulse(8, 40);
        pulse(16, 40);
        pulse(2, 40);
        en_cur = 1'b0;
        pulse(5, 20);
        en_cur = 1'b1;
        add_seg(1'b0, 20);
        pulse(5, 4);
        pulse(5, 40);
        pulse(4, 30);
        pulse(7, 30);
        pulse(9, 30);
        pulse(19, 30);
        pulse(20, 30);
        pulse(32, 30);
        pulse(63, 30);
        add_seg(1'b1, 8);
        en_cur = 1'b0;
        add_seg(1'b1, 4);
        add_seg(1'b0, 30);
        add_seg(1'b1, 8);
        en_cur = 1'b1;
        add_seg(1'b1, 4);
        add_seg(1'b0, 30);
        pulse(100, 40);
        pulse(64, 40);
    endtask

    task automatic gen_random();
        int kind, n, k;
        len    = 0;
        en_cur = 1'b1;
        add_seg(1'b0, 5);
        while (len < MAXC - 300) begin
            kind   = int'($urandom_range(0, 9));
            en_cur = ($urandom_range(0, 5) != 0);
            if (kind == 0) n = int'($urandom_range(1, 2));
            else if (kind < 5) n = blist[$urandom_range(0, 15)];
            else if (kind < 9) n = int'($urandom_range(3, 35));
            else n = int'($urandom_range(40, 100));
            k = int'($urandom_range(0, n));
            add_seg(1'b1, k);
            en_cur = ($urandom_range(0, 5) != 0);
            add_seg(1'b1, n - k);
            en_cur = ($urandom_range(0, 5) != 0);
            add_seg(1'b0, int'($urandom_range(3, 24)));
        end
        add_seg(1'b0, 120);
    endtask

    task automatic reset_mid_measure();
        reset     = 1'b1;
        sensor_in = 1'b0;
        enable    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset     = 1'b0;
        sensor_in = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("mid_busy", int'(busy), 1);
        reset     = 1'b1;
        sensor_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            check($sformatf("post_rst_coin@%0d", c), int'(coin), 3);
            check($sformatf("post_rst_strobe@%0d", c), int'(coin_strobe), 0);
            check($sformatf("post_rst_reject@%0d", c), int'(reject), 0);
            check($sformatf("post_rst_busy@%0d", c), int'(busy), 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gen_directed();
        build_model();
        play();
        reset_mid_measure();
        for (int r = 0; r < 4; r++) begin
            gen_random();
            build_model();
            play();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
